// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage, with a
// word-serial burst engine that writes back the victim line and refills the missed one.
module dcache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 6
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rd_req_i,
    input  logic        wr_req_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  write_en_i,
    output logic [31:0] read_data_o,
    output logic        miss_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);
    localparam int WORDS   = 1 << LINE_ADDR_LEN;
    localparam int SETS    = 1 << SET_ADDR_LEN;
    localparam int IDX_LEN = SET_ADDR_LEN + LINE_ADDR_LEN;
    localparam int TAG_LEN = 32 - IDX_LEN - 2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t                   state_q;
    logic [LINE_ADDR_LEN-1:0] cnt_q;
    logic [SETS-1:0]          valid_q;
    logic [SETS-1:0]          dirty_q;
    logic [TAG_LEN-1:0]       tag_q  [SETS];
    logic [31:0]              data_q [SETS*WORDS];

    logic [LINE_ADDR_LEN-1:0] req_word_s;
    logic [SET_ADDR_LEN-1:0]  req_set_s;
    logic [TAG_LEN-1:0]       req_tag_s;
    logic [TAG_LEN-1:0]       victim_tag_s;
    logic [IDX_LEN-1:0]       req_idx_s;
    logic [IDX_LEN-1:0]       beat_idx_s;
    logic                     hit_s;
    logic                     line_dirty_s;
    logic                     access_s;
    logic                     beat_s;
    logic                     last_beat_s;
    logic                     serve_s;
    logic                     store_s;
    logic                     miss_s;
    logic                     unused_s;

    assign req_word_s   = addr_i[LINE_ADDR_LEN+1:2];
    assign req_set_s    = addr_i[IDX_LEN+1:LINE_ADDR_LEN+2];
    assign req_tag_s    = addr_i[31:IDX_LEN+2];
    assign unused_s     = ^addr_i[1:0];
    assign victim_tag_s = tag_q[req_set_s];
    assign req_idx_s    = {req_set_s, req_word_s};
    assign beat_idx_s   = {req_set_s, cnt_q};
    assign hit_s        = valid_q[req_set_s] && (victim_tag_s == req_tag_s);
    assign line_dirty_s = valid_q[req_set_s] && dirty_q[req_set_s];
    assign access_s     = rd_req_i || wr_req_i;
    assign beat_s       = mem_req_o && mem_ready_i;
    assign last_beat_s  = (cnt_q == {LINE_ADDR_LEN{1'b1}});
    // DONE serves the held request exactly like an IDLE hit.
    assign serve_s      = (state_q == S_DONE) || ((state_q == S_IDLE) && hit_s);
    assign store_s      = serve_s && wr_req_i;
    assign read_data_o  = data_q[req_idx_s];
    assign miss_o       = miss_s && rst_ni;

    // Stall request and memory-side beat outputs decoded from the burst state.
    always_comb begin
        miss_s      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        case (state_q)
            S_IDLE: begin
                miss_s = access_s && !hit_s;
            end
            S_WRITEBACK: begin
                miss_s      = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {victim_tag_s, req_set_s, cnt_q, 2'b00};
                mem_wdata_o = data_q[beat_idx_s];
            end
            S_REFILL: begin
                miss_s     = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {req_tag_s, req_set_s, cnt_q, 2'b00};
            end
            S_DONE: begin
                miss_s = 1'b0;
            end
            default: begin
                miss_s = 1'b0;
            end
        endcase
    end

    // Burst FSM, beat counter and per-line valid/dirty state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= {LINE_ADDR_LEN{1'b0}};
            valid_q <= {SETS{1'b0}};
            dirty_q <= {SETS{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (store_s) begin
                        dirty_q[req_set_s] <= 1'b1;
                    end
                    if (access_s && !hit_s) begin
                        cnt_q   <= {LINE_ADDR_LEN{1'b0}};
                        state_q <= line_dirty_s ? S_WRITEBACK : S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (beat_s) begin
                        if (last_beat_s) begin
                            cnt_q   <= {LINE_ADDR_LEN{1'b0}};
                            state_q <= S_REFILL;
                        end else begin
                            cnt_q <= cnt_q + LINE_ADDR_LEN'(1);
                        end
                    end
                end
                S_REFILL: begin
                    if (beat_s) begin
                        if (last_beat_s) begin
                            cnt_q              <= {LINE_ADDR_LEN{1'b0}};
                            valid_q[req_set_s] <= 1'b1;
                            dirty_q[req_set_s] <= 1'b0;
                            state_q            <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + LINE_ADDR_LEN'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (store_s) begin
                        dirty_q[req_set_s] <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Data and tag arrays: refill beats and strobed stores; contents survive reset.
    always_ff @(posedge clk_i) begin
        if ((state_q == S_REFILL) && beat_s) begin
            data_q[beat_idx_s] <= mem_rdata_i;
            if (last_beat_s) begin
                tag_q[req_set_s] <= req_tag_s;
            end
        end else if (store_s) begin
            for (int b = 0; b < 4; b++) begin
                if (write_en_i[b]) begin
                    data_q[req_idx_s][8*b +: 8] <= write_data_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache in the MEM stage of the RV32I core. It serves word-aligned loads and byte-strobed stores from the pipeline. Its `read_data` feeds the load data-extension stage, which uses `addr[1:0]` and the load type to pick and extend bytes. Misses stall the pipeline through `miss` while a word-serial burst engine writes back the victim line and refills from main memory.

## Interface
- `LINE_ADDR_LEN`, default 3: log2 of words per line (8 words = 32 B).
- `SET_ADDR_LEN`, default 6: log2 of sets (64 lines).
- Derived: word offset is `addr[LINE_ADDR_LEN+1:2]`; set is the next `SET_ADDR_LEN` bits; tag is the remaining upper bits.
- `clk  input  1`: sole clock, rising edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `rd_req  input  1`: load request.
- `wr_req  input  1`: store request.
- `addr  input  32`: byte address. Bits [1:0] are ignored here.
- `write_data  input  32`: store data, already lane-aligned.
- `write_en  input  4`: byte strobes. Bit i writes `write_data[8i+7:8i]`.
- `read_data  output  32`: full word at `addr[31:2]`. Valid when `rd_req && !miss`.
- `miss  output  1`: stall request to the pipeline.
- `mem_req  output  1`: burst beat request to main memory.
- `mem_we  output  1`: 1 = writeback beat, 0 = refill beat.
- `mem_addr  output  32`: word address of the current beat. Bits [1:0] are 0.
- `mem_wdata  output  32`: writeback word.
- `mem_rdata  input  32`: refill word.
- `mem_ready  input  1`: beat handshake. A beat completes at a rising edge with `mem_req && mem_ready`.

## Operation
- **Arrays.**
  - Per line: `valid`, `dirty`, tag, and `2^LINE_ADDR_LEN` data words.
  - Reset clears all `valid` and `dirty` bits. Data and tag arrays are not reset.
  - Array reads are combinational.
- **Hit condition:** `valid[set] && tag[set]==addr tag`.
- **FSM states:** IDLE, WRITEBACK, REFILL, DONE. Reset state is IDLE.
- **IDLE**
  - Hit with `rd_req`: `read_data` = addressed word.
  - Hit with `wr_req`: at the clock edge, write the strobed bytes and set `dirty[set]`.
  - Miss on a dirty valid line: go to WRITEBACK, beat counter 0.
  - Miss otherwise: go to REFILL, beat counter 0.
- **WRITEBACK**
  - `mem_req`=1, `mem_we`=1.
  - `mem_addr` = {victim tag, set, counter, 2'b00}.
  - `mem_wdata` = victim word[counter].
  - On each completed beat, counter increments. On the last beat (counter = 2^LINE_ADDR_LEN−1): go to REFILL, counter 0.
- **REFILL**
  - `mem_req`=1, `mem_we`=0.
  - `mem_addr` = {request tag, set, counter, 2'b00}.
  - Each completed beat writes `mem_rdata` into word[counter].
  - On the last beat: set `valid`=1, `dirty`=0, tag = request tag; go to DONE.
- **DONE**
  - One cycle. The pending access is served exactly as an IDLE hit; a store sets `dirty`.
  - Then go to IDLE.
- **`miss`** = `(rd_req||wr_req) && !hit` in IDLE, or state ∈ {WRITEBACK, REFILL}. It is 0 in DONE.
- `mem_req`=0 in IDLE and DONE. `mem_we`, `mem_addr` and `mem_wdata` are 0 there.
- **Request stability:** the pipeline holds `addr`, `rd_req`, `wr_req`, `write_data` and `write_en` stable while `miss`=1.
- **Both requests high:** treated as a store. `read_data` is undefined.
- **`wr_req` with `write_en`=0:** still allocates on a miss, writes no bytes, and sets `dirty`.

## Timing
- **Reset values:**
  - `miss`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. `read_data` is don't-care.
  - `miss` is forced to 0 while `rst_n`=0.
- **Hit latency:** 0 cycles. `miss`=0 in the request cycle, and the pipeline register captures `read_data` at that edge.
- **Miss timing:**
  - `miss` rises combinationally in the request cycle.
  - `mem_req` rises on the next cycle.
  - Clean miss: `miss` stays high for N refill beats plus all `mem_ready`-low wait cycles, then drops in DONE.
  - Dirty miss: 2N beats plus wait cycles, where N = 2^LINE_ADDR_LEN.
- **Wait states:** while `mem_ready`=0, `mem_addr`, `mem_we`, `mem_wdata` and the counter hold.
- **Counter wrap:** the counter never wraps inside a burst. Its terminal value triggers the state change.
- **Reset mid-burst:**
  - Immediately (asynchronously): `mem_req`=0, state IDLE, all `valid`/`dirty` cleared.
  - A partially refilled line is never marked valid. Dirty data is lost.

## Test plan
Parameters at defaults: set = `addr[10:5]`, tag = `addr[31:11]`. Memory model returns `0x11110000+i` for word i of line 0x40.

1. Reset, then `rd_req` at 0x40 → `miss`=1 that cycle; 8 refill beats with `mem_addr` 0x40, 0x44 … 0x5C and `mem_we`=0; DONE cycle has `miss`=0 and `read_data`=0x11110000.
2. `rd_req` at 0x44 after test 1 → `miss`=0 in the same cycle, `read_data`=0x11110001, no `mem_req`.
3. `wr_req` at 0x48 with `write_data`=0xAABBCCDD and `write_en`=4'b0010, then `rd_req` at 0x48 → `miss`=0 both cycles, `read_data`=0x1111CC02.
4. `rd_req` at 0x840 (set 2, tag 1) → 8 writeback beats with `mem_we`=1 at `mem_addr` 0x40…0x5C, where the beat at 0x48 carries 0x1111CC02; then 8 refill beats from 0x840; `miss` drops in DONE.
5. Hold `mem_ready`=0 for 5 cycles at refill beat 3 → `mem_addr` stays 0x84C, `miss` stays 1, total miss duration grows by exactly 5 cycles.
6. Drive `rst_n`=0 during refill beat 3 → `mem_req` and `miss` go to 0 with no clock edge; after release, `rd_req` at 0x840 misses again and starts a clean refill with no writeback.
